// File: rtl/sp_ram_banked_if.sv
// Request/response bundle for the banked single-port RAM, one lane per port.
// Latency: none, signal bundle only.
// Backpressure: an ungranted requester holds its request fields until gnt_o is seen.
interface sp_ram_banked_if #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_PORTS-1:0]                   req_i;
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]   addr_i;
    logic [NUM_PORTS-1:0]                   we_i;
    logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0] be_i;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   wdata_i;
    logic [NUM_PORTS-1:0]                   gnt_o;
    logic [NUM_PORTS-1:0]                   rvalid_o;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   rdata_o;

    modport master (
        output req_i, addr_i, we_i, be_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o
    );

    modport slave (
        input  req_i, addr_i, we_i, be_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o
    );
endinterface

// File: rtl/sp_ram_banked.sv
// Multi-port RAM built from word-interleaved single-port banks with per-bank round-robin arbitration.
// Latency: gnt_o same cycle as request; rvalid_o RD_LATENCY cycles after the grant edge.
// Backpressure: a bank conflict withholds gnt_o; the losing port must hold its request, nothing is queued.
module sp_ram_banked #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_BYTES  = 4096,
    parameter int NUM_PORTS  = 2,
    parameter int NUM_BANKS  = 2,
    parameter int RD_LATENCY = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    sp_ram_banked_if.slave bus
);
    localparam int WB   = DATA_WIDTH / 8;
    localparam int OFFS = (WB > 1) ? $clog2(WB) : 0;
    localparam int ROWS = NUM_BYTES / (WB * NUM_BANKS);
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int BW   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int PW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    if (DATA_WIDTH <= 0 || (DATA_WIDTH % 8) != 0) begin : g_bad_data_width
        $error("sp_ram_banked: DATA_WIDTH must be a positive multiple of 8");
    end
    if (NUM_BANKS < 1 || (NUM_BANKS & (NUM_BANKS - 1)) != 0) begin : g_bad_num_banks
        $error("sp_ram_banked: NUM_BANKS must be a power of 2");
    end
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_rd_latency
        $error("sp_ram_banked: RD_LATENCY must be 1 or 2");
    end
    if (ROWS < 1 || (NUM_BYTES % (WB * NUM_BANKS)) != 0) begin : g_bad_num_bytes
        $error("sp_ram_banked: NUM_BYTES must be a multiple of DATA_WIDTH/8*NUM_BANKS");
    end

    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] word_idx;
    logic [NUM_PORTS-1:0][BW-1:0]         bank_of;
    logic [NUM_PORTS-1:0][RW-1:0]         row_of;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rd_word;

    logic [NUM_BANKS-1:0][PW-1:0]         ptr_q;
    logic [NUM_BANKS-1:0][PW-1:0]         ptr_nxt;
    logic [NUM_PORTS-1:0]                 gnt;

    logic [NUM_BANKS-1:0]                 wr_en;
    logic [NUM_BANKS-1:0][RW-1:0]         wr_row;
    logic [NUM_BANKS-1:0][WB-1:0]         wr_be;
    logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] wr_dat;

    logic [DATA_WIDTH-1:0]                mem [NUM_BANKS][ROWS];

    logic [NUM_PORTS-1:0]                 s1_vld;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] s1_dat;
    logic [NUM_PORTS-1:0]                 rvalid_q;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdata_q;

    // Split each port address into bank/row (upper bits wrap) and fetch the current word.
    always_comb begin
        word_idx = '0;
        bank_of  = '0;
        row_of   = '0;
        rd_word  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            word_idx[p] = bus.addr_i[p] >> OFFS;
            bank_of[p]  = BW'(word_idx[p] % ADDR_WIDTH'(NUM_BANKS));
            row_of[p]   = RW'((word_idx[p] / ADDR_WIDTH'(NUM_BANKS)) % ADDR_WIDTH'(ROWS));
            rd_word[p]  = mem[bank_of[p]][row_of[p]];
        end
    end

    // Per bank: grant the first requester at or after the pointer and steer its write.
    always_comb begin
        int   p;
        logic taken;
        p       = 0;
        taken   = 1'b0;
        gnt     = '0;
        wr_en   = '0;
        wr_row  = '0;
        wr_be   = '0;
        wr_dat  = '0;
        ptr_nxt = ptr_q;
        for (int b = 0; b < NUM_BANKS; b++) begin
            taken = 1'b0;
            for (int k = 0; k < NUM_PORTS; k++) begin
                p = (int'(ptr_q[b]) + k) % NUM_PORTS;
                if (!taken && bus.req_i[p] && bank_of[p] == BW'(b)) begin
                    taken      = 1'b1;
                    gnt[p]     = 1'b1;
                    ptr_nxt[b] = PW'((p + 1) % NUM_PORTS);
                    wr_en[b]   = bus.we_i[p];
                    wr_row[b]  = row_of[p];
                    wr_be[b]   = bus.be_i[p];
                    wr_dat[b]  = bus.wdata_i[p];
                end
            end
        end
    end

    // Grants are suppressed while reset is held so nothing is accepted or written.
    assign bus.gnt_o    = gnt & {NUM_PORTS{rst_n}};
    assign bus.rvalid_o = rvalid_q;
    assign bus.rdata_o  = rdata_q;

    // Round-robin pointers advance only for banks that granted this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_nxt;
        end
    end

    // Byte-masked bank writes; storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int i = 0; i < WB; i++) begin
                if (rst_n && wr_en[b] && wr_be[b][i]) begin
                    mem[b][wr_row[b]][8*i +: 8] <= wr_dat[b][8*i +: 8];
                end
            end
        end
    end

    // Response pipe: pre-write word captured at the grant edge, optional second stage, rdata holds when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld   <= '0;
            s1_dat   <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            s1_vld <= gnt;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (gnt[p]) begin
                    s1_dat[p] <= rd_word[p];
                end
            end
            if (RD_LATENCY == 1) begin
                rvalid_q <= gnt;
                for (int p = 0; p < NUM_PORTS; p++) begin
                    if (gnt[p]) begin
                        rdata_q[p] <= rd_word[p];
                    end
                end
            end else begin
                rvalid_q <= s1_vld;
                for (int p = 0; p < NUM_PORTS; p++) begin
                    if (s1_vld[p]) begin
                        rdata_q[p] <= s1_dat[p];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_sp_ram_banked.sv
// Self-checking bench for sp_ram_banked: flat byte-memory model plus per-bank round-robin model.
// Latency: model schedules each response RD_LATENCY cycles after its grant.
// Backpressure: stimulus holds ungranted requests using the model's grant prediction.
module tb_sp_ram_banked;
    localparam int AW  = 16;
    localparam int DW  = 32;
    localparam int NBY = 4096;
    localparam int NP  = 2;
    localparam int NB  = 2;
    localparam int LAT = 1;
    localparam int WB  = DW / 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    sp_ram_banked_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    sp_ram_banked #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BYTES(NBY),
        .NUM_PORTS(NP), .NUM_BANKS(NB), .RD_LATENCY(LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int              due;
        logic [DW-1:0]   dat;
        logic [DW-1:0]   msk;
    } rsp_t;

    logic [7:0]      mb [NBY];
    bit              mv [NBY];
    int              ptr_m [NB];
    rsp_t            rq [NP][$];
    logic [DW-1:0]   last_d [NP];
    logic [DW-1:0]   last_m [NP];
    logic [NP-1:0]   mgnt = '0;
    int              cyc = 0;

    // Compare every cycle: responses due now, rdata hold, grants; then commit the cycle to the model.
    always @(negedge clk) begin
        logic [NP-1:0] eg;
        int            nptr [NB];
        rsp_t          r;
        int            base;
        cyc++;
        if (!rst_n) begin
            chk("rst_gnt", 64'(bus.gnt_o), 64'(0));
            chk("rst_rvalid", 64'(bus.rvalid_o), 64'(0));
            for (int p = 0; p < NP; p++) begin
                chk("rst_rdata", 64'(bus.rdata_o[p]), 64'(0));
                rq[p].delete();
                last_d[p] = '0;
                last_m[p] = '1;
            end
            for (int b = 0; b < NB; b++) ptr_m[b] = 0;
            mgnt = '0;
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (rq[p].size() > 0 && rq[p][0].due == cyc) begin
                    r = rq[p].pop_front();
                    chk("rvalid_due", 64'(bus.rvalid_o[p]), 64'(1));
                    if (r.msk != 0)
                        chk("rdata", 64'(bus.rdata_o[p] & r.msk), 64'(r.dat & r.msk));
                    last_d[p] = r.dat;
                    last_m[p] = r.msk;
                end else begin
                    chk("rvalid_idle", 64'(bus.rvalid_o[p]), 64'(0));
                    if (last_m[p] != 0)
                        chk("rdata_hold", 64'(bus.rdata_o[p] & last_m[p]), 64'(last_d[p] & last_m[p]));
                end
            end
            eg = '0;
            for (int b = 0; b < NB; b++) begin
                nptr[b] = ptr_m[b];
                for (int k = 0; k < NP; k++) begin
                    int p;
                    p = (ptr_m[b] + k) % NP;
                    if (nptr[b] == ptr_m[b] && !(|(eg & ~eg)) && bus.req_i[p] &&
                        ((int'(bus.addr_i[p]) / WB) % NB) == b && !eg[p] && nptr[b] == ptr_m[b]) begin
                        eg[p]   = 1'b1;
                        nptr[b] = (p + 1) % NP;
                        if (nptr[b] == ptr_m[b]) nptr[b] = nptr[b] + NP; // mark taken even if pointer value unchanged
                    end
                end
                ptr_m[b] = nptr[b] % NP;
            end
            chk("gnt", 64'(bus.gnt_o), 64'(eg));
            for (int p = 0; p < NP; p++) begin
                if (eg[p]) begin
                    base  = ((int'(bus.addr_i[p]) / WB) * WB) % NBY;
                    r.due = cyc + LAT;
                    for (int i = 0; i < WB; i++) begin
                        r.dat[8*i +: 8] = mb[base + i];
                        r.msk[8*i +: 8] = mv[base + i] ? 8'hFF : 8'h00;
                    end
                    rq[p].push_back(r);
                end
            end
            for (int p = 0; p < NP; p++) begin
                if (eg[p] && bus.we_i[p]) begin
                    base = ((int'(bus.addr_i[p]) / WB) * WB) % NBY;
                    for (int i = 0; i < WB; i++) begin
                        if (bus.be_i[p][i]) begin
                            mb[base + i] = bus.wdata_i[p][8*i +: 8];
                            mv[base + i] = 1'b1;
                        end
                    end
                end
            end
            mgnt = eg;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic r, input logic [AW-1:0] a, input logic w,
                            input logic [WB-1:0] be, input logic [DW-1:0] d);
        bus.req_i[p]   = r;
        bus.addr_i[p]  = a;
        bus.we_i[p]    = w;
        bus.be_i[p]    = be;
        bus.wdata_i[p] = d;
    endtask

    task automatic idle();
        bus.req_i = '0;
    endtask

    initial begin
        logic [NP-1:0] g [4];
        int            cnt0, cnt1;

        set_port(0, 1'b1, 16'h0000, 1'b1, 4'hF, 32'h0);
        set_port(1, 1'b1, 16'h0004, 1'b1, 4'hF, 32'h0);
        @(negedge clk);
        chk("lit_rst_gnt", 64'(bus.gnt_o), 64'(0));
        chk("lit_rst_rvalid", 64'(bus.rvalid_o), 64'(0));
        tick(); tick();
        rst_n = 1'b1;
        idle();
        tick();

        // write then read back the same word
        set_port(0, 1'b1, 16'h0010, 1'b1, 4'hF, 32'hDEADBEEF);
        tick();
        set_port(0, 1'b1, 16'h0010, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        chk("lit_rd_gnt", 64'(bus.gnt_o[0]), 64'(1));
        tick();
        idle();
        @(negedge clk);
        chk("lit_rd_rvalid", 64'(bus.rvalid_o[0]), 64'(1));
        chk("lit_rd_data", 64'(bus.rdata_o[0]), 64'h0000_0000_DEAD_BEEF);
        tick();

        // partial byte-enable write, write response carries pre-write word
        set_port(0, 1'b1, 16'h0020, 1'b1, 4'hF, 32'h11223344);
        tick();
        set_port(0, 1'b1, 16'h0020, 1'b1, 4'h5, 32'hAABBCCDD);
        tick();
        set_port(0, 1'b1, 16'h0020, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        chk("lit_be_prewrite", 64'(bus.rdata_o[0]), 64'h0000_0000_1122_3344);
        tick();
        idle();
        @(negedge clk);
        chk("lit_be_merge", 64'(bus.rdata_o[0]), 64'h0000_0000_11BB_33DD);
        tick();

        // distinct banks in the same cycle
        set_port(0, 1'b1, 16'h0000, 1'b0, 4'h0, 32'h0);
        set_port(1, 1'b1, 16'h0004, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        chk("lit_par_gnt", 64'(bus.gnt_o), 64'(2'b11));
        tick();
        idle();
        @(negedge clk);
        chk("lit_par_rvalid", 64'(bus.rvalid_o), 64'(2'b11));
        tick();

        // address wrap-around
        set_port(1, 1'b1, 16'h1010, 1'b1, 4'hF, 32'hCAFEF00D);
        tick();
        idle();
        set_port(0, 1'b1, 16'h0010, 1'b0, 4'h0, 32'h0);
        tick();
        idle();
        @(negedge clk);
        chk("lit_wrap_rvalid", 64'(bus.rvalid_o[0]), 64'(1));
        chk("lit_wrap_data", 64'(bus.rdata_o[0]), 64'h0000_0000_CAFE_F00D);
        tick();

        // reset while a read is in flight
        set_port(0, 1'b1, 16'h0000, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        chk("lit_inflight_gnt", 64'(bus.gnt_o[0]), 64'(1));
        #1;
        rst_n = 1'b0;
        set_port(1, 1'b1, 16'h0008, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        chk("lit_rst_mid_rvalid", 64'(bus.rvalid_o), 64'(0));
        chk("lit_rst_mid_gnt", 64'(bus.gnt_o), 64'(0));
        chk("lit_rst_mid_rdata", 64'(bus.rdata_o[0]), 64'(0));
        tick(); tick();
        rst_n = 1'b1;
        idle();
        @(negedge clk);
        chk("lit_post_rst_rvalid", 64'(bus.rvalid_o), 64'(0));
        tick();

        // contention on bank0 right after reset: pointer starts at port 0
        set_port(0, 1'b1, 16'h0000, 1'b0, 4'h0, 32'h0);
        set_port(1, 1'b1, 16'h0008, 1'b0, 4'h0, 32'h0);
        cnt0 = 0;
        cnt1 = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            g[i] = bus.gnt_o;
            cnt0 += int'(bus.rvalid_o[0]);
            cnt1 += int'(bus.rvalid_o[1]);
            tick();
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cnt0 += int'(bus.rvalid_o[0]);
            cnt1 += int'(bus.rvalid_o[1]);
            tick();
        end
        chk("lit_rr_g0", 64'(g[0]), 64'(2'b01));
        chk("lit_rr_g1", 64'(g[1]), 64'(2'b10));
        chk("lit_rr_g2", 64'(g[2]), 64'(2'b01));
        chk("lit_rr_g3", 64'(g[3]), 64'(2'b10));
        chk("lit_rr_cnt0", 64'(cnt0), 64'(2));
        chk("lit_rr_cnt1", 64'(cnt1), 64'(2));

        // random traffic over a small, wrapping address window with occasional resets
        for (int c = 0; c < 2000; c++) begin
            if (rst_n && $urandom_range(0, 199) == 0) rst_n = 1'b0;
            else rst_n = 1'b1;
            for (int p = 0; p < NP; p++) begin
                if (!(bus.req_i[p] && !mgnt[p])) begin
                    set_port(p, $urandom_range(0, 3) != 0, AW'($urandom) & 16'hF03F,
                             1'($urandom), WB'($urandom), DW'($urandom));
                end
            end
            tick();
        end
        rst_n = 1'b1;
        idle();
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
